// File: rtl/ysyx_23060203_mem_arb.sv
// Two-requester (IFU/LSU) memory arbiter with a single outstanding transaction.
// Define YSYX_23060203_ARB_RR_EN for round-robin ties; otherwise LSU wins ties.
module ysyx_23060203_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_resp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_W-1:0]     mem_resp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner_lsu;
    logic   sel_ifu;
    logic   sel_lsu;
    logic   grant;

`ifdef YSYX_23060203_ARB_RR_EN
    logic last_lsu;

    // Pointer resets to "LSU granted last" so the first tie goes to IFU
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_lsu <= 1'b1;
        end else if (grant) begin
            last_lsu <= sel_lsu;
        end
    end
`endif

    always_comb begin
        sel_lsu = 1'b0;
        sel_ifu = 1'b0;
        if (state == IDLE) begin
`ifdef YSYX_23060203_ARB_RR_EN
            sel_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
`else
            sel_lsu = lsu_req_valid;
`endif
            sel_ifu = ifu_req_valid && !sel_lsu;
        end
    end

    assign grant = sel_ifu | sel_lsu;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = REQ;
            REQ:     if (mem_req_ready) state_nxt = RESP;
            RESP:    if (mem_resp_valid && mem_resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // IFU grants carry no write information into the latched payload
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_lsu     <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if (grant) begin
            owner_lsu     <= sel_lsu;
            mem_req_addr  <= sel_lsu ? lsu_req_addr : ifu_req_addr;
            mem_req_wen   <= sel_lsu & lsu_req_wen;
            mem_req_wdata <= sel_lsu ? lsu_req_wdata : '0;
            mem_req_wmask <= sel_lsu ? lsu_req_wmask : '0;
        end
    end

    assign ifu_req_ready  = sel_ifu;
    assign lsu_req_ready  = sel_lsu;
    assign mem_req_valid  = (state == REQ);

    assign mem_resp_ready = (state == RESP) && (owner_lsu ? lsu_resp_ready : ifu_resp_ready);
    assign ifu_resp_valid = (state == RESP) && !owner_lsu && mem_resp_valid;
    assign lsu_resp_valid = (state == RESP) &&  owner_lsu && mem_resp_valid;
    assign ifu_resp_data  = ((state == RESP) && !owner_lsu) ? mem_resp_rdata : '0;
    assign lsu_resp_rdata = ((state == RESP) &&  owner_lsu) ? mem_resp_rdata : '0;

endmodule

// File: tb/tb_ysyx_23060203_mem_arb.sv
// Directed self-checking bench for ysyx_23060203_mem_arb.
// Tie-break expectations follow YSYX_23060203_ARB_RR_EN when it is defined.
module tb_ysyx_23060203_mem_arb;

    logic        clk;
    logic        rstn;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_resp_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060203_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
        lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    endtask

    task automatic test_reset();
        rstn = 0;
        clear_inputs();
        #1;
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
        n_checks++; if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== 69'd0) begin n_fail++; $display("[TB] FAIL rst_payload: got %h/%b/%h/%h want zeros", mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
        n_checks++; if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 5'b0) begin n_fail++; $display("[TB] FAIL rst_handshakes: got %b want 00000", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_resp_ready}); end
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_ifu_read();
        @(negedge clk);
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL read_ifu_ready: got %b want 1", ifu_req_ready); end
        n_checks++; if (lsu_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL read_lsu_ready: got %b want 0", lsu_req_ready); end
        @(negedge clk);
        ifu_req_valid = 0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL read_mem_valid: got %b want 1", mem_req_valid); end
        n_checks++; if (mem_req_addr !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL read_mem_addr: got %h want 80000000", mem_req_addr); end
        n_checks++; if ({mem_req_wen, mem_req_wmask, mem_req_wdata} !== 37'd0) begin n_fail++; $display("[TB] FAIL read_mem_wr: got %b/%h/%h want zeros", mem_req_wen, mem_req_wmask, mem_req_wdata); end
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413; ifu_resp_ready = 1; lsu_resp_ready = 0;
        #1;
        n_checks++; if (ifu_resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL read_resp_valid: got %b want 1", ifu_resp_valid); end
        n_checks++; if (ifu_resp_data !== 32'h0000_0413) begin n_fail++; $display("[TB] FAIL read_resp_data: got %h want 00000413", ifu_resp_data); end
        n_checks++; if (lsu_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL read_lsu_resp: got %b want 0", lsu_resp_valid); end
        n_checks++; if (mem_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL read_mem_resp_ready: got %b want 1", mem_resp_ready); end
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL read_mem_valid_resp: got %b want 0", mem_req_valid); end
        @(negedge clk);
        #1;
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 3'b0) begin n_fail++; $display("[TB] FAIL read_idle_stray: got %b want 000", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}); end
        clear_inputs();
    endtask

    task automatic test_lsu_write();
        @(negedge clk);
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; mem_req_ready = 1;
        #1;
        n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_lsu_ready: got %b want 1", lsu_req_ready); end
        n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ifu_ready_grant: got %b want 0", ifu_req_ready); end
        @(negedge clk);
        lsu_req_valid = 0;
        #1;
        n_checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin n_fail++; $display("[TB] FAIL wr_payload: got %b/%h/%b/%h/%h want 1/80001000/1/deadbeef/f", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); end
        n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ifu_ready_req: got %b want 0", ifu_req_ready); end
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h5555_AAAA; lsu_resp_ready = 1; ifu_resp_ready = 0;
        #1;
        n_checks++; if ({lsu_resp_valid, ifu_resp_valid, mem_resp_ready} !== 3'b101) begin n_fail++; $display("[TB] FAIL wr_resp: got lsu/ifu/rdy %b want 101", {lsu_resp_valid, ifu_resp_valid, mem_resp_ready}); end
        n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_ifu_ready_resp: got %b want 0", ifu_req_ready); end
        ifu_req_valid = 0;
        @(negedge clk);
        mem_resp_valid = 0; lsu_resp_ready = 0; lsu_req_valid = 1;
        #1;
        n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_back_idle: got %b want 1", lsu_req_ready); end
        clear_inputs();
    endtask

    task automatic test_tie();
        logic        exp_lsu;
        logic [31:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060203_ARB_RR_EN
            exp_lsu = (i % 2) == 1;
`else
            exp_lsu = 1'b1;
`endif
            exp_addr = exp_lsu ? (32'h9000_0000 + 32'(i * 4)) : (32'h8000_0100 + 32'(i * 4));
            @(negedge clk);
            ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100 + 32'(i * 4);
            lsu_req_valid = 1; lsu_req_addr = 32'h9000_0000 + 32'(i * 4); lsu_req_wen = 0;
            mem_req_ready = 1;
            #1;
            n_checks++; if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin n_fail++; $display("[TB] FAIL tie_grant%0d: got ifu/lsu %b want %b", i, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu}); end
            @(negedge clk);
            ifu_req_valid = 0; lsu_req_valid = 0;
            #1;
            n_checks++; if (mem_req_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL tie_addr%0d: got %h want %h", i, mem_req_addr, exp_addr); end
            @(negedge clk);
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1000 + 32'(i);
            ifu_resp_ready = 1; lsu_resp_ready = 1;
            #1;
            n_checks++; if ({ifu_resp_valid, lsu_resp_valid} !== {~exp_lsu, exp_lsu}) begin n_fail++; $display("[TB] FAIL tie_resp%0d: got ifu/lsu %b want %b", i, {ifu_resp_valid, lsu_resp_valid}, {~exp_lsu, exp_lsu}); end
            n_checks++; if ((exp_lsu ? lsu_resp_rdata : ifu_resp_data) !== 32'h1000 + 32'(i)) begin n_fail++; $display("[TB] FAIL tie_data%0d: got %h want %h", i, exp_lsu ? lsu_resp_rdata : ifu_resp_data, 32'h1000 + 32'(i)); end
            @(negedge clk);
            clear_inputs();
        end
        ifu_req_valid = 1;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL tie_ifu_alone: got %b want 1", ifu_req_ready); end
        ifu_req_valid = 0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_wen = 1;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wmask = 4'b0011; mem_req_ready = 0;
        #1;
        n_checks++; if (lsu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_grant: got %b want 1", lsu_req_ready); end
        @(negedge clk);
        lsu_req_valid = 0; lsu_req_wdata = 32'hFFFF_FFFF; ifu_req_valid = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if ({mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask} !== {1'b1, 32'h8000_2000, 32'h1234_5678, 4'b0011}) begin n_fail++; $display("[TB] FAIL bp_req_hold%0d: got %b/%h/%h/%h want 1/80002000/12345678/3", k, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask); end
            n_checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_req_nogrant%0d: got %b want 00", k, {ifu_req_ready, lsu_req_ready}); end
            @(negedge clk);
        end
        mem_req_ready = 1;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_req_last: got %b want 1", mem_req_valid); end
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0BAD_F00D; lsu_resp_ready = 0; ifu_resp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if ({mem_resp_ready, lsu_resp_valid, ifu_resp_valid} !== 3'b010) begin n_fail++; $display("[TB] FAIL bp_resp_hold%0d: got rdy/lsu/ifu %b want 010", k, {mem_resp_ready, lsu_resp_valid, ifu_resp_valid}); end
            n_checks++; if (ifu_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_resp_nogrant%0d: got %b want 0", k, ifu_req_ready); end
            @(negedge clk);
        end
        lsu_resp_ready = 1;
        #1;
        n_checks++; if (mem_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_resp_release: got %b want 1", mem_resp_ready); end
        ifu_req_valid = 0;
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if ({mem_req_valid, lsu_resp_valid, mem_resp_ready} !== 3'b000) begin n_fail++; $display("[TB] FAIL bp_idle: got %b want 000", {mem_req_valid, lsu_resp_valid, mem_resp_ready}); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010; mem_req_ready = 1;
        @(negedge clk);
        ifu_req_valid = 0;
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_0001; ifu_resp_ready = 1;
        rstn = 0;
        #1;
        n_checks++; if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask} !== 70'd0) begin n_fail++; $display("[TB] FAIL rmid_mem_req: got %b/%b/%h/%h/%h want zeros", mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask); end
        n_checks++; if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready, ifu_req_ready, lsu_req_ready} !== 5'b0) begin n_fail++; $display("[TB] FAIL rmid_handshakes: got %b want 00000", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready, ifu_req_ready, lsu_req_ready}); end
        n_checks++; if (ifu_resp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL rmid_data: got %h want 0", ifu_resp_data); end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        #1;
        n_checks++; if ({ifu_resp_valid, mem_resp_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL rmid_stray: got %b want 00", {ifu_resp_valid, mem_resp_ready}); end
        @(negedge clk);
        mem_resp_valid = 0; ifu_resp_ready = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0020; mem_req_ready = 1;
        #1;
        n_checks++; if (ifu_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_regrant: got %b want 1", ifu_req_ready); end
        @(negedge clk);
        ifu_req_valid = 0;
        #1;
        n_checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0020}) begin n_fail++; $display("[TB] FAIL rmid_req: got %b/%h want 1/80000020", mem_req_valid, mem_req_addr); end
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0013; ifu_resp_ready = 1;
        #1;
        n_checks++; if ({ifu_resp_valid, ifu_resp_data} !== {1'b1, 32'h0000_0013}) begin n_fail++; $display("[TB] FAIL rmid_resp: got %b/%h want 1/00000013", ifu_resp_valid, ifu_resp_data); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_tie();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
